reg_file_x31: RTL
=================

// Module: reg_file_x31
// PURPOSE
//   32 x 64-bit architectural register file; the direct downstream consumer of the
//   5:32 write-select decoder. Each register loads WriteData on the clock edge when
//   its one-hot regSelect bit is high. Two combinational read ports feed the ALU
//   operand stage. X31 is hard-wired to zero (XZR): it is never written and always
//   reads as 0. A sticky error flag catches illegal multi-hot selects.
// PARAMETERS
//   WIDTH   64   data width of each register and of all data ports
//   NREGS   32   number of register addresses; index NREGS-1 is XZR
// PORTS
//   clk           input   1      rising-edge clock, only clock in the block
//   reset         input   1      synchronous, active-high reset
//   regSelect     input   32     one-hot write select from the 5:32 decoder; all-zero = no write
//   WriteData     input   WIDTH  data written to the selected register
//   ReadRegister1 input   5      read port 1 address
//   ReadRegister2 input   5      read port 2 address
//   ReadData1     output  WIDTH  contents of register ReadRegister1
//   ReadData2     output  WIDTH  contents of register ReadRegister2
//   selErr        output  1      sticky: a multi-hot regSelect was seen
// BEHAVIOUR
//   - Reset (reset=1 at a rising clk edge): all registers 0 and selErr=0.
//     ReadData1/2 are therefore 0 from the first edge after reset. Reset wins
//     over a write presented on the same edge.
//   - Write: at a rising edge, if regSelect has exactly one bit i set with
//     i < 31, reg[i] <= WriteData. The new value is visible on the read ports
//     one cycle later (1-cycle write latency).
//   - regSelect all-zero: no register changes.
//   - regSelect[31] set alone: ignored, no state change, selErr unchanged.
//   - Two or more bits set: no register is written on that edge; selErr <= 1
//     and holds until reset. Bit 31 counts toward the multi-hot check.
//   - Read: ReadDataN = reg[ReadRegisterN] combinationally (no clock). Address
//     31 returns 0. Both ports may address the same register.
//   - Read during write, same register, same cycle: returns the OLD value
//     unless REGFILE_BYPASS_EN is defined (see CONFIGURATION).
//   - No internal FSM. State is the register array plus selErr. The one-hot
//     check is combinational: popcount(regSelect) > 1.
// CONFIGURATION
//   REGFILE_BYPASS_EN  defined: write-through forwarding. If regSelect is
//     exactly one-hot at bit i < 31 and ReadRegisterN == i, ReadDataN = WriteData
//     in the same cycle. Never applies to address 31 or to multi-hot selects.
//   not defined: reads always return stored contents; a same-cycle write
//     becomes visible one cycle later.
// TESTING
//   1. reset=1 for 1 edge, then read all 32 addresses -> every ReadData = 0, selErr = 0.
//   2. regSelect=32'h0000_0004, WriteData=64'hDEAD_BEEF_0000_0001, 1 edge;
//      ReadRegister1=2 -> ReadData1=64'hDEAD_BEEF_0000_0001. Other registers still 0.
//   3. regSelect=32'h8000_0000, WriteData=all ones, 1 edge; ReadRegister2=31
//      -> ReadData2=0, selErr=0.
//   4. regSelect=32'h0000_0030 (bits 4 and 5), WriteData=64'h55, 1 edge
//      -> X4 and X5 unchanged, selErr=1. regSelect=0 for 3 edges -> selErr still 1.
//      reset for 1 edge -> selErr=0.
//   5. X7=64'h11; drive regSelect=32'h80, WriteData=64'h22, ReadRegister1=7 before
//      the edge -> ReadData1=64'h22 with REGFILE_BYPASS_EN, 64'h11 without;
//      64'h22 after the edge in both builds.
//   6. regSelect=32'h0000_0200, reset=1 on the same edge -> X9=0 after the edge
//      (reset has priority).

Source files
------------

// File: rtl/reg_file_x31.sv
// 32 x WIDTH architectural register file with X31 hard-wired to zero and a sticky multi-hot select flag.
// Optional build macro: REGFILE_BYPASS_EN enables same-cycle write-through forwarding on both read ports.
module reg_file_x31 #(
  parameter  int unsigned WIDTH = 64,
  parameter  int unsigned NREGS = 32,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREGS-1:0] regSelect,
  input  logic [WIDTH-1:0] WriteData,
  input  logic [AW-1:0]    ReadRegister1,
  input  logic [AW-1:0]    ReadRegister2,
  output logic [WIDTH-1:0] ReadData1,
  output logic [WIDTH-1:0] ReadData2,
  output logic             selErr
);

  localparam logic [AW-1:0] XZR = AW'(NREGS - 1);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic             sel_err_q;
  logic             sel_err_d;
  logic             one_hot_c;
  logic             multi_hot_c;
  logic [NREGS-1:0] write_en_c;

  // Select classification: popcount of the decoder output.
  always_comb begin
    one_hot_c   = ($countones(regSelect) == 1);
    multi_hot_c = ($countones(regSelect) > 1);
  end

  // Per-register write enables; XZR never takes a write.
  always_comb begin
    write_en_c = '0;
    for (int unsigned i = 0; i < NREGS - 1; i++) begin
      write_en_c[i] = regSelect[i] & one_hot_c;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NREGS; i++) begin
      regs_d[i] = write_en_c[i] ? WriteData : regs_q[i];
    end
    regs_d[NREGS-1] = '0;
    sel_err_d       = sel_err_q | multi_hot_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q    <= '{default: '0};
      sel_err_q <= 1'b0;
    end else begin
      regs_q    <= regs_d;
      sel_err_q <= sel_err_d;
    end
  end

  // Combinational read ports; address XZR always returns zero.
  always_comb begin
    ReadData1 = (ReadRegister1 == XZR) ? '0 : regs_q[ReadRegister1];
    ReadData2 = (ReadRegister2 == XZR) ? '0 : regs_q[ReadRegister2];
`ifdef REGFILE_BYPASS_EN
    if (write_en_c[ReadRegister1]) begin
      ReadData1 = WriteData;
    end
    if (write_en_c[ReadRegister2]) begin
      ReadData2 = WriteData;
    end
`endif
  end

  assign selErr = sel_err_q;

endmodule
